// File: rtl/vga_motion_pkg.sv
// Shared types and constants for the sprite motion controller.
// Pulled in by sprite_motion_ctrl and its synchronizer.
package vga_motion_pkg;

    localparam int POS_W    = 10;
    localparam int H_ACTIVE = 640;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2
    } mode_t;

    typedef logic [POS_W-1:0] pos_t;
    // One extra bit of headroom so a step near the right edge cannot wrap.
    typedef logic [POS_W:0]   pos_ext_t;

    // Move pos by step towards the requested side, landing on the limit
    // whenever the move would reach or cross it.
    function automatic pos_ext_t step_clamp(
        input pos_ext_t pos,
        input pos_ext_t step,
        input logic     right,
        input pos_ext_t lo,
        input pos_ext_t hi
    );
        pos_ext_t res;
        if (right) begin
            if ((pos + step) >= hi) begin
                res = hi;
            end else begin
                res = pos + step;
            end
        end else begin
            if (pos <= (lo + step)) begin
                res = lo;
            end else begin
                res = pos - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_btn_sync.sv
// btn_sync: two-flop synchronizer for the raw ui_in pins.
// Bit order is set by the instantiating module.
module btn_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous X position controller: manual buttons vs. bounce attract mode.
// Optional build macro MOTION_ACCEL_EN adds hold-to-accelerate for manual moves.
module sprite_motion_ctrl
    import vga_motion_pkg::*;
#(
    parameter int X_MIN       = 20,
    parameter int X_MAX       = H_ACTIVE - 20,
    parameter int X_RESET     = 320,
    parameter int STEP        = 1,
    parameter int IDLE_FRAMES = 180
`ifdef MOTION_ACCEL_EN
    ,
    parameter int MAX_STEP     = 4,
    parameter int ACCEL_FRAMES = 15
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             auto_en,
    output logic [POS_W-1:0] x_center,
    output logic             dir_right,
    output logic [1:0]       mode,
    output logic             moving
);

    localparam int IDLE_W = (IDLE_FRAMES > 1) ? $clog2(IDLE_FRAMES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FRAMES - 1);
    localparam pos_ext_t X_MIN_C   = pos_ext_t'(X_MIN);
    localparam pos_ext_t X_MAX_C   = pos_ext_t'(X_MAX);
    localparam pos_ext_t STEP_C    = pos_ext_t'(STEP);

    logic [2:0]        sync_in_s;
    logic [2:0]        sync_out_s;
    logic              l_s;
    logic              r_s;
    logic              auto_s;
    logic              any_s;
    logic              single_s;

    mode_t             mode_r;
    mode_t             mode_nxt_s;
    pos_t              x_center_r;
    pos_t              x_nxt_s;
    logic              dir_right_r;
    logic              dir_nxt_s;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [IDLE_W-1:0] idle_nxt_s;
    logic              moving_r;

    pos_ext_t          step_s;
    pos_ext_t          man_pos_s;
    pos_ext_t          auto_pos_s;
    logic              auto_hit_s;
    pos_t              man_x_s;
    logic              man_dir_s;

    assign sync_in_s = {auto_en, btn_right, btn_left};

    btn_sync #(
        .WIDTH (3)
    ) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sync_in_s),
        .dout  (sync_out_s)
    );

    assign l_s      = sync_out_s[0];
    assign r_s      = sync_out_s[1];
    assign auto_s   = sync_out_s[2];
    assign any_s    = l_s | r_s;
    assign single_s = l_s ^ r_s;

`ifdef MOTION_ACCEL_EN
    localparam int STEP_W = $clog2(MAX_STEP + 1);
    localparam int ACC_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);

    logic [STEP_W-1:0] step_r;
    logic [ACC_W-1:0]  acc_cnt_r;
    logic              hold_valid_r;
    logic              held_right_r;
    logic              cont_s;

    // A hold only continues while the same single button stays down.
    assign cont_s = hold_valid_r && single_s && (held_right_r == r_s);
    assign step_s = cont_s ? pos_ext_t'(step_r) : STEP_C;

    // Hold tracking: counts held frames and raises the step up to MAX_STEP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r       <= STEP_W'(STEP);
            acc_cnt_r    <= {ACC_W{1'b0}};
            hold_valid_r <= 1'b0;
            held_right_r <= 1'b0;
        end else if (!single_s) begin
            step_r       <= STEP_W'(STEP);
            acc_cnt_r    <= {ACC_W{1'b0}};
            hold_valid_r <= 1'b0;
            held_right_r <= 1'b0;
        end else if (frame_tick) begin
            if (cont_s) begin
                if (acc_cnt_r == ACC_LAST) begin
                    acc_cnt_r <= {ACC_W{1'b0}};
                    if (step_r < STEP_W'(MAX_STEP)) begin
                        step_r <= step_r + STEP_W'(1);
                    end else begin
                        step_r <= step_r;
                    end
                end else begin
                    acc_cnt_r <= acc_cnt_r + ACC_W'(1);
                end
            end else begin
                hold_valid_r <= 1'b1;
                held_right_r <= r_s;
                acc_cnt_r    <= ACC_W'(1);
                step_r       <= STEP_W'(STEP);
            end
        end else begin
            step_r <= step_r;
        end
    end
`else
    assign step_s = STEP_C;
`endif

    assign man_pos_s  = step_clamp({1'b0, x_center_r}, step_s, r_s, X_MIN_C, X_MAX_C);
    assign auto_pos_s = step_clamp({1'b0, x_center_r}, STEP_C, dir_right_r, X_MIN_C, X_MAX_C);
    assign auto_hit_s = dir_right_r ? (auto_pos_s == X_MAX_C) : (auto_pos_s == X_MIN_C);

    // Manual update candidate: only a single pressed button moves on a frame tick.
    always_comb begin
        man_x_s   = x_center_r;
        man_dir_s = dir_right_r;
        if (frame_tick && single_s) begin
            man_x_s   = pos_t'(man_pos_s);
            man_dir_s = r_s;
        end else begin
            man_x_s   = x_center_r;
            man_dir_s = dir_right_r;
        end
    end

    // Mode FSM, idle counter and position selection.
    always_comb begin
        mode_nxt_s = mode_r;
        x_nxt_s    = x_center_r;
        dir_nxt_s  = dir_right_r;
        idle_nxt_s = idle_cnt_r;
        case (mode_r)
            IDLE: begin
                if (any_s) begin
                    mode_nxt_s = MANUAL;
                    idle_nxt_s = IDLE_ZERO;
                    x_nxt_s    = man_x_s;
                    dir_nxt_s  = man_dir_s;
                end else if (!auto_s) begin
                    idle_nxt_s = IDLE_ZERO;
                end else if (frame_tick) begin
                    if (idle_cnt_r == IDLE_LAST) begin
                        mode_nxt_s = AUTO;
                        idle_nxt_s = IDLE_ZERO;
                    end else begin
                        idle_nxt_s = idle_cnt_r + IDLE_ONE;
                    end
                end else begin
                    idle_nxt_s = idle_cnt_r;
                end
            end
            MANUAL: begin
                x_nxt_s   = man_x_s;
                dir_nxt_s = man_dir_s;
                if (frame_tick && !any_s) begin
                    mode_nxt_s = IDLE;
                    idle_nxt_s = IDLE_ZERO;
                end else begin
                    mode_nxt_s = MANUAL;
                end
            end
            AUTO: begin
                if (any_s) begin
                    mode_nxt_s = MANUAL;
                    x_nxt_s    = man_x_s;
                    dir_nxt_s  = man_dir_s;
                end else if (!auto_s) begin
                    mode_nxt_s = IDLE;
                    idle_nxt_s = IDLE_ZERO;
                end else if (frame_tick) begin
                    x_nxt_s = pos_t'(auto_pos_s);
                    if (auto_hit_s) begin
                        dir_nxt_s = ~dir_right_r;
                    end else begin
                        dir_nxt_s = dir_right_r;
                    end
                end else begin
                    x_nxt_s = x_center_r;
                end
            end
            default: begin
                mode_nxt_s = IDLE;
                idle_nxt_s = IDLE_ZERO;
            end
        endcase
    end

    // State and output registers; moving flags any cycle the position changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r      <= IDLE;
            x_center_r  <= pos_t'(X_RESET);
            dir_right_r <= 1'b1;
            idle_cnt_r  <= IDLE_ZERO;
            moving_r    <= 1'b0;
        end else begin
            mode_r      <= mode_nxt_s;
            x_center_r  <= x_nxt_s;
            dir_right_r <= dir_nxt_s;
            idle_cnt_r  <= idle_nxt_s;
            moving_r    <= (x_nxt_s != x_center_r);
        end
    end

    assign x_center  = x_center_r;
    assign dir_right = dir_right_r;
    assign mode      = mode_r;
    assign moving    = moving_r;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: every expected move is queued before its
// frame tick and a negedge monitor pops it when the DUT pulses moving.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       auto_en = 1'b0;
    logic [9:0] x_center;
    logic       dir_right;
    logic [1:0] mode;
    logic       moving;

    typedef struct packed {
        logic [9:0] x;
        logic       dir;
        logic [1:0] mode;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_x;
    int   step;

    sprite_motion_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .auto_en    (auto_en),
        .x_center   (x_center),
        .dir_right  (dir_right),
        .mode       (mode),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int dir, input int md);
        exp_t e;
        e.x    = 10'(x);
        e.dir  = dir[0];
        e.mode = 2'(md);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_btn(input logic l, input logic r);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        repeat (3) @(negedge clk);
    endtask

    // One isolated single-frame press: always a fresh hold at the base step.
    task automatic tap(input logic right);
        exp_x = right ? exp_x + 1 : exp_x - 1;
        push(exp_x, int'(right), 1);
        set_btn(~right, right);
        tick();
        set_btn(1'b0, 1'b0);
        tick();
    endtask

    // Monitor: every moving pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && moving === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_move_x", int'(x_center), -1);
            end else begin
                e = exp_q.pop_front();
                check("move_x", int'(x_center), int'(e.x));
                check("move_dir", int'(dir_right), int'(e.dir));
                check("move_mode", int'(mode), int'(e.mode));
            end
        end
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_x", int'(x_center), 320);
        check("rst_dir", int'(dir_right), 1);
        check("rst_mode", int'(mode), 0);
        check("rst_moving", int'(moving), 0);
        rst_n = 1'b1;
        exp_x = 320;

        // 1: idle frames never move
        repeat (5) tick();
        check("idle_x", int'(x_center), 320);
        check("idle_mode", int'(mode), 0);

        // 2: hold left for 10 frames, then release
        set_btn(1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            push(320 - i, 0, 1);
            tick();
        end
        exp_x = 310;
        check("left10_x", int'(x_center), 310);
        check("left10_dir", int'(dir_right), 0);
        check("left10_mode", int'(mode), 1);
        set_btn(1'b0, 1'b0);
        tick();
        check("release_mode", int'(mode), 0);
        check("release_x", int'(x_center), 310);

        // 4: both buttons at 320 do not move
        for (int i = 0; i < 10; i++) tap(1'b1);
        set_btn(1'b1, 1'b1);
        repeat (4) tick();
        check("both_x", int'(x_center), 320);
        check("both_mode", int'(mode), 1);
        set_btn(1'b0, 1'b0);
        tick();

        // 6: hold right for 60 frames
        set_btn(1'b0, 1'b1);
        for (int k = 1; k <= 60; k++) begin
`ifdef MOTION_ACCEL_EN
            step = 1 + (k - 1) / 15;
`else
            step = 1;
`endif
            exp_x = exp_x + step;
            push(exp_x, 1, 1);
            tick();
        end
`ifdef MOTION_ACCEL_EN
        check("hold60_x", int'(x_center), 470);
`else
        check("hold60_x", int'(x_center), 380);
`endif
        set_btn(1'b0, 1'b0);
        tick();

        // 3: from 21, left clamps at X_MIN; only the first frame moves
        while (exp_x > 21) tap(1'b0);
        check("at21_x", int'(x_center), 21);
        set_btn(1'b1, 1'b0);
        push(20, 0, 1);
        exp_x = 20;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clamp_min_x", int'(x_center), 20);
        end
        check("clamp_min_mode", int'(mode), 1);
        set_btn(1'b0, 1'b0);
        tick();

        // 5: attract mode entry and bounce at X_MAX
        while (exp_x < 618) tap(1'b1);
        auto_en = 1'b1;
        repeat (3) @(negedge clk);
        repeat (179) tick();
        check("auto_pre_mode", int'(mode), 0);
        tick();
        check("auto_mode", int'(mode), 2);
        check("auto_entry_x", int'(x_center), 618);
        push(619, 1, 2);
        tick();
        push(620, 0, 2);
        tick();
        push(619, 0, 2);
        tick();
        @(negedge clk) btn_right = 1'b1;
        repeat (3) @(negedge clk);
        check("auto_to_manual_mode", int'(mode), 1);
        btn_right = 1'b0;
        auto_en   = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        check("after_auto_mode", int'(mode), 0);
        check("after_auto_x", int'(x_center), 619);

        // Mid-frame reset, then the first move waits for the next tick
        set_btn(1'b0, 1'b1);
        push(620, 1, 1);
        tick();
        check("clamp_max_x", int'(x_center), 620);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("midrst_x", int'(x_center), 320);
        check("midrst_dir", int'(dir_right), 1);
        check("midrst_mode", int'(mode), 0);
        check("midrst_moving", int'(moving), 0);
        btn_right = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        set_btn(1'b0, 1'b1);
        check("post_rst_hold_x", int'(x_center), 320);
        push(321, 1, 1);
        tick();
        set_btn(1'b0, 1'b0);
        tick();

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
